// File: rtl/ks_sub_pipe_16b.sv
`default_nettype none
// ============================================================================
// Module      : ks_sub_pipe_16b
// Description : Pipelined 16-bit Kogge-Stone subtractor, D = X - Y - Bin,
//               computed as X + ~Y + ~Bin through a radix-2 prefix network.
//               Registers sit between prefix levels. The block has a
//               valid/ready handshake plus borrow, overflow and zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ks_sub_pipe_16b #(
  parameter int WIDTH     = 16,
  parameter bit BYPASS_S2 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  // The prefix spans (1,2,4,8) are hard-wired for exactly 16 bits.
  generate
    if (WIDTH != 16) begin : g_width_check
      $fatal(1, "ks_sub_pipe_16b: WIDTH must be 16");
    end
  endgenerate

  // One Kogge-Stone carry-operator level: (G,P)[i] o (G,P)[i-span].
  function automatic logic [2*WIDTH-1:0] prefix_level(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input int               span
  );
    logic [WIDTH-1:0] g_n;
    logic [WIDTH-1:0] p_n;
    g_n = g;
    p_n = p;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= span) begin
        g_n[i] = g[i] | (p[i] & g[i-span]);
        p_n[i] = p[i] & p[i-span];
      end
    end
    return {g_n, p_n};
  endfunction

  // Global advance enable: the whole pipe moves unless the output is stuck.
  logic en;
  logic out_valid_q;
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------- stage 1
  logic [WIDTH-1:0] y_inv;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] s1_g_d, s1_p_d, s1_p0_d;
  logic             s1_c0_d, s1_x15_d, s1_y15_d, s1_v_d;
  logic [WIDTH-1:0] s1_g_q, s1_p_q, s1_p0_q;
  logic             s1_c0_q, s1_x15_q, s1_y15_q, s1_v_q;

  // Bitwise generate/propagate of x + ~y, then the span-1 prefix level.
  always_comb begin
    y_inv            = ~y;
    g0               = x & y_inv;
    s1_p0_d          = x ^ y_inv;
    {s1_g_d, s1_p_d} = prefix_level(g0, s1_p0_d, 1);
    s1_c0_d          = ~bin;
    s1_x15_d         = x[WIDTH-1];
    s1_y15_d         = y[WIDTH-1];
    s1_v_d           = in_valid & in_ready;
  end

  // Stage-1 register; everything holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_g_q   <= '0;
      s1_p_q   <= '0;
      s1_p0_q  <= '0;
      s1_c0_q  <= 1'b0;
      s1_x15_q <= 1'b0;
      s1_y15_q <= 1'b0;
      s1_v_q   <= 1'b0;
    end else if (en) begin
      s1_g_q   <= s1_g_d;
      s1_p_q   <= s1_p_d;
      s1_p0_q  <= s1_p0_d;
      s1_c0_q  <= s1_c0_d;
      s1_x15_q <= s1_x15_d;
      s1_y15_q <= s1_y15_d;
      s1_v_q   <= s1_v_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [WIDTH-1:0] l2_g, l2_p;
  logic [WIDTH-1:0] s2_g_d, s2_p_d;
  logic [WIDTH-1:0] s2_g, s2_p, s2_p0;
  logic             s2_c0, s2_x15, s2_y15, s2_v;

  // Prefix levels with spans 2 and 4.
  always_comb begin
    {l2_g, l2_p}     = prefix_level(s1_g_q, s1_p_q, 2);
    {s2_g_d, s2_p_d} = prefix_level(l2_g, l2_p, 4);
  end

  generate
    if (BYPASS_S2) begin : g_s2_bypass
      assign s2_g   = s2_g_d;
      assign s2_p   = s2_p_d;
      assign s2_p0  = s1_p0_q;
      assign s2_c0  = s1_c0_q;
      assign s2_x15 = s1_x15_q;
      assign s2_y15 = s1_y15_q;
      assign s2_v   = s1_v_q;
    end else begin : g_s2_reg
      logic [WIDTH-1:0] s2_g_q, s2_p_q, s2_p0_q;
      logic             s2_c0_q, s2_x15_q, s2_y15_q, s2_v_q;

      // Middle pipeline register between the span-4 and span-8 levels.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_g_q   <= '0;
          s2_p_q   <= '0;
          s2_p0_q  <= '0;
          s2_c0_q  <= 1'b0;
          s2_x15_q <= 1'b0;
          s2_y15_q <= 1'b0;
          s2_v_q   <= 1'b0;
        end else if (en) begin
          s2_g_q   <= s2_g_d;
          s2_p_q   <= s2_p_d;
          s2_p0_q  <= s1_p0_q;
          s2_c0_q  <= s1_c0_q;
          s2_x15_q <= s1_x15_q;
          s2_y15_q <= s1_y15_q;
          s2_v_q   <= s1_v_q;
        end
      end

      assign s2_g   = s2_g_q;
      assign s2_p   = s2_p_q;
      assign s2_p0  = s2_p0_q;
      assign s2_c0  = s2_c0_q;
      assign s2_x15 = s2_x15_q;
      assign s2_y15 = s2_y15_q;
      assign s2_v   = s2_v_q;
    end
  endgenerate

  // ---------------------------------------------------------------- stage 3
  logic [WIDTH-1:0] g4, p4;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] d_d, d_q;
  logic             bout_d, ovf_d, zero_d, out_valid_d;
  logic             bout_q, ovf_q, zero_q;

  // Span-8 level, fold in the carry-in, then form the difference and flags.
  always_comb begin
    {g4, p4} = prefix_level(s2_g, s2_p, 8);
    carry    = '0;
    carry[0] = s2_c0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = g4[i] | (p4[i] & s2_c0);
    end
    d_d         = s2_p0 ^ carry[WIDTH-1:0];
    bout_d      = ~carry[WIDTH];
    ovf_d       = (s2_x15 != s2_y15) & (d_d[WIDTH-1] != s2_x15);
    zero_d      = ~|d_d;
    out_valid_d = s2_v;
  end

  // Output register; holds result and flags stable during backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      d_q         <= d_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ks_sub_pipe_16b.sv
`default_nettype none
// ============================================================================
// Module      : tb_ks_sub_pipe_16b
// Description : Self-checking bench for ks_sub_pipe_16b: directed cases,
//               streaming, backpressure, reset flush and random regression
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ks_sub_pipe_16b;

  localparam bit BYPASS = 1'b0;
  localparam int LAT    = BYPASS ? 2 : 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] d;
  logic        bout, ovf, zero;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [18:0] exp_q[$];
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  ks_sub_pipe_16b #(.WIDTH(16), .BYPASS_S2(BYPASS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf), .zero(zero)
  );

  // Reference: plain integer subtraction, packed as {zero, ovf, bout, d}.
  function automatic logic [18:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    int          ua, ub, diff, sa, sb, sr;
    logic [15:0] r;
    logic        rb, ro, rz;
    ua   = int'(a);
    ub   = int'(b);
    diff = ua - ub - int'(c);
    r    = diff[15:0];
    rb   = (diff < 0);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sr   = sa - sb - int'(c);
    ro   = (sr > 32767) || (sr < -32768);
    rz   = (r == 16'h0000);
    return {rz, ro, rb, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: sampled on the falling edge, reflecting what the next
  // rising edge will do.
  logic        stall_prev = 1'b0;
  logic [18:0] held = '0;
  always @(negedge clk) begin
    logic [18:0] got;
    got = {zero, ovf, bout, d};
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", got, held);
      end
      if (out_valid) begin
        check("result_expected", (exp_q.size() > 0), 1);
        if (out_ready && exp_q.size() > 0) check("result", got, exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      held       = got;
      if (in_valid && in_ready) exp_q.push_back(ref_sub(x, y, bin));
    end
  end

  // Random backpressure, active only during the regression phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
  end

  // Present one beat and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic r;
    int   guard;
    guard    = 0;
    in_valid = 1'b1;
    x        = a;
    y        = b;
    bin      = c;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      guard++;
    end while (!r && guard < 1000);
    if (!r) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 1000 cycles");
    end
    #1 in_valid = 1'b0;
  endtask

  // Single beat on an empty pipe with literal expectations and latency check.
  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
    int cyc;
    cyc = 0;
    send(a, b, c);
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 20);
    check({name, "_latency"}, cyc, LAT);
    check({name, "_d"}, d, ed);
    check({name, "_bout"}, bout, eb);
    check({name, "_ovf"}, ovf, eo);
    check({name, "_zero"}, zero, ez);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {zero, ovf, bout, d}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed arithmetic cases
    directed("t1_5m3",      16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    directed("t2_0m1",      16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    directed("t2_8000m1",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    directed("t3_zero",     16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    directed("t3_both",     16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    directed("t3_eq_bin",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream: six results on consecutive cycles
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!out_valid && cyc < 30);
        check("stream_first_valid", out_valid, 1);
        for (int k = 1; k < 6; k++) begin
          @(negedge clk);
          check("stream_consecutive", out_valid, 1);
        end
      end
    join
    drain("stream_drain");

    // Backpressure: stall five cycles once the first result appears
    fork
      begin
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        cyc = 0;
        do begin
          @(posedge clk);
          #1;
          cyc++;
        end while (!out_valid && cyc < 30);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall_drain");

    // Reset with two beats in flight
    send(16'h1111, 16'h0001, 1'b0);
    send(16'h2222, 16'h0002, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_outputs", {zero, ovf, bout, d}, 0);
    repeat (6) begin
      @(negedge clk);
      check("flush_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    directed("t6_after_rst", 16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0);

    // Random regression
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
